hub75_bcm_scanner: RTL and testbench
====================================

Name: hub75_bcm_scanner

Overview:
- Parametrised successor to the single-pixel HUB75 driver: scans a full panel from an external framebuffer with binary-coded-modulation (BCM) colour depth and programmable global brightness.
- Sits between a dual-row pixel store (BRAM) and the panel pins (R1/G1/B1/R2/G2/B2, row address, LAT, OE, CLK).
- Sequence per row pair and bit plane: shift a full row of one plane, blank, latch, then display for a plane-weighted time.

Parameters:
- COLS, 64: pixels per shifted row; power of 2.
- ROW_PAIRS, 16: scanned row pairs; power of 2.
- ROW_W, 4: log2(ROW_PAIRS); row address width.
- COL_W, 6: log2(COLS).
- BPP, 4: bits per colour channel, which is also the number of BCM planes.
- CLK_DIV, 2: sclk half-period in clk cycles; must be at least 1.
- BASE_T, 256: plane-0 display window in clk cycles; must be at least 1.
- LAT_W, 1: LAT high width in clk cycles; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- enable  in  1  run scanning.
- brightness  in  8  OE on-time scale; 0 means dark.
- fb_rd  out  1  framebuffer read strobe.
- fb_addr  out  ROW_W+COL_W  {row, col} read address.
- fb_data  in  6*BPP  {b2,g2,r2,b1,g1,r1}, each BPP bits; valid exactly 1 cycle after fb_rd.
- r1,g1,b1,r2,g2,b2  out  1 each  panel colour data.
- addr  out  ROW_W  panel row select.
- sclk  out  1  panel shift clock.
- lat  out  1  panel latch.
- oe_n  out  1  panel output enable, active low.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, rst=0): state=IDLE; all colour outputs 0, addr=0, sclk=0, lat=0, oe_n=1, fb_rd=0, frame_done=0, busy=0, row=0, plane=0. Reset mid-frame aborts immediately, with no completion of the current row.
- FSM states: IDLE, PREFETCH, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE: oe_n=1. If enable=1, go to PREFETCH with row=0, plane=0.
- PREFETCH (2 cycles): the read for column 0 is issued on the first cycle.
- Column timing: column c of SHIFT starts at cycle S_c and occupies 2*CLK_DIV cycles.
  - The fb read for column c is issued (fb_rd=1, fb_addr={row,c}) at S_c-2.
  - Colour outputs take bit[plane] of each fb_data field at S_c and hold for the whole column.
  - sclk=0 for the first CLK_DIV cycles, then 1 for the remaining CLK_DIV cycles.
  - fb_rd is 0 whenever no read is being issued.
- After column COLS-1, go to BLANK for 1 cycle: sclk=0, oe_n=1.
- LATCH lasts LAT_W cycles: addr<=row on the first cycle, lat=1 throughout, oe_n=1.
- DISPLAY lasts BASE_T<<plane cycles, with counter d running 0 upward.
  - oe_n=0 iff (d>>plane) < brightness_s, where brightness_s is brightness sampled on the first DISPLAY cycle.
  - On-time is therefore min(brightness,BASE_T)<<plane cycles. brightness=0 keeps oe_n=1 while timing is unchanged.
  - lat=0 throughout.
- Advance after DISPLAY: plane+1. At the plane wrap (BPP-1 to 0), row+1.
- Frame end: after row ROW_PAIRS-1 and plane BPP-1, frame_done=1 during the final DISPLAY cycle.
  - If enable=1 at that cycle, go to PREFETCH with no gap.
  - Otherwise go to IDLE.
- enable deassert mid-frame: the frame completes, then the FSM enters IDLE. enable is sampled only in IDLE and on the final cycle of a frame.
- Frame length: ROW_PAIRS * sum over p of (2 + 2*CLK_DIV*COLS + 1 + LAT_W + (BASE_T<<p)) cycles.
- Counters: all counters are sized to hold their maximum value with no overflow. addr wraps ROW_PAIRS-1 to 0.

Test Plan:
1. Reset: rst=0 asserted mid-SHIFT -> outputs take their reset values asynchronously, before the next clk edge. After release with enable=0, the block stays IDLE (busy=0, oe_n=1).
2. Small config (COLS=4, ROW_PAIRS=2, BPP=2, CLK_DIV=1, BASE_T=4, LAT_W=1), brightness=2, enable held high -> frame_done pulses every 72 cycles. oe_n is low for 2 cycles on plane 0 and 4 cycles on plane 1.
3. Same config, fb model returning r1 field = col (col 0..3) -> r1 per shifted column is 0,1,0,1 on plane 0 and 0,0,1,1 on plane 1. Four sclk rising edges per row, each at the midpoint of its column. lat is 1 cycle wide, after BLANK.
4. brightness=0 -> oe_n is never low, and the frame period is still 72. brightness=200 with BASE_T=4 -> oe_n is low for the whole DISPLAY window.
5. enable dropped in the middle of row 0 -> the full frame completes, frame_done pulses once, then busy=0 and there are no further fb_rd.
6. Address sequencing over 2 frames -> addr follows 0,0,1,1,0,0,1,1 per plane-DISPLAY and changes only while lat=1 and oe_n=1. fb_addr row field matches.

Source files
------------

// File: rtl/hub75_bcm_scanner.sv
// -----------------------------------------------------------------------------
// hub75_bcm_scanner
//   Scans a HUB75 LED panel from an external dual-row framebuffer using
//   binary-coded modulation (one bit plane per pass) with a global
//   brightness scale applied to each plane's display window.
//
//   Per row pair and bit plane:
//     PREFETCH (2) -> SHIFT (COLS columns of 2*CLK_DIV cycles) -> BLANK (1)
//     -> LATCH (LAT_W) -> DISPLAY (BASE_T << plane)
//
// Ports
//   clk, rst        system clock, asynchronous active-low reset
//   enable          run scanning (sampled in IDLE and on a frame's last cycle)
//   brightness      on-time scale for OE, 0 keeps the panel dark
//   fb_rd, fb_addr  framebuffer read strobe and {row, col} address
//   fb_data         {b2,g2,r2,b1,g1,r1}, BPP bits each, valid 1 cycle after fb_rd
//   r1..b2          panel colour data
//   addr            panel row select
//   sclk, lat, oe_n panel shift clock, latch, active-low output enable
//   frame_done      one-cycle pulse on the final DISPLAY cycle of a frame
//   busy            high whenever the scanner is not idle
// -----------------------------------------------------------------------------
module hub75_bcm_scanner #(
    parameter int COLS      = 64,
    parameter int ROW_PAIRS = 16,
    parameter int ROW_W     = 4,
    parameter int COL_W     = 6,
    parameter int BPP       = 4,
    parameter int CLK_DIV   = 2,
    parameter int BASE_T    = 256,
    parameter int LAT_W     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [7:0]             brightness,
    output logic                   fb_rd,
    output logic [ROW_W+COL_W-1:0] fb_addr,
    input  logic [6*BPP-1:0]       fb_data,
    output logic                   r1,
    output logic                   g1,
    output logic                   b1,
    output logic                   r2,
    output logic                   g2,
    output logic                   b2,
    output logic [ROW_W-1:0]       addr,
    output logic                   sclk,
    output logic                   lat,
    output logic                   oe_n,
    output logic                   frame_done,
    output logic                   busy
);

    localparam int PH_W = $clog2(2 * CLK_DIV);
    localparam int PL_W = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int LC_W = (LAT_W > 1) ? $clog2(LAT_W) : 1;
    // Longest window is BASE_T << (BPP-1); the counter must also hold that length.
    localparam int D_W  = $clog2((BASE_T << (BPP - 1)) + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFETCH = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_BLANK    = 3'd3,
        ST_LATCH    = 3'd4,
        ST_DISPLAY  = 3'd5
    } state_t;

    state_t            state_r;
    logic [ROW_W-1:0]  row_r;
    logic [PL_W-1:0]   plane_r;
    logic [COL_W-1:0]  col_r;
    logic [PH_W-1:0]   ph_r;
    logic              pf_r;
    logic [LC_W-1:0]   lc_r;
    logic [D_W-1:0]    d_r;
    logic [7:0]        bright_r;

    logic [PH_W-1:0]   ph_next_s;
    logic [D_W-1:0]    d_next_s;
    logic [D_W-1:0]    win_last_s;
    logic              last_plane_s;
    logic              last_seg_s;
    logic [PL_W-1:0]   next_plane_s;
    logic [ROW_W-1:0]  next_row_s;

    // Selects bit[pl] of each of the six colour fields, packed {b2,g2,r2,b1,g1,r1}.
    function automatic logic [5:0] plane_bits(input logic [6*BPP-1:0] data,
                                              input logic [PL_W-1:0]  pl);
        logic [5:0] bits;
        bits = 6'd0;
        for (int f = 0; f < 6; f++) begin
            bits[f] = data[f*BPP + int'(pl)];
        end
        return bits;
    endfunction

    // OE is on while the plane-scaled display count is below the sampled brightness.
    function automatic logic oe_on(input logic [D_W-1:0]  d,
                                   input logic [PL_W-1:0] pl,
                                   input logic [7:0]      br);
        return (32'(d >> pl) < 32'(br));
    endfunction

    assign ph_next_s    = ph_r + PH_W'(1);
    assign d_next_s     = d_r + D_W'(1);
    assign win_last_s   = (D_W'(BASE_T) << plane_r) - D_W'(1);
    assign last_plane_s = (plane_r == PL_W'(BPP - 1));
    assign last_seg_s   = last_plane_s && (row_r == ROW_W'(ROW_PAIRS - 1));
    assign next_plane_s = last_plane_s ? PL_W'(0) : (plane_r + PL_W'(1));
    // Row address wraps naturally because ROW_PAIRS is a power of two.
    assign next_row_s   = last_plane_s ? (row_r + ROW_W'(1)) : row_r;

    // Scan FSM; every output is registered and set for the cycle that follows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            row_r      <= ROW_W'(0);
            plane_r    <= PL_W'(0);
            col_r      <= COL_W'(0);
            ph_r       <= PH_W'(0);
            pf_r       <= 1'b0;
            lc_r       <= LC_W'(0);
            d_r        <= D_W'(0);
            bright_r   <= 8'd0;
            fb_rd      <= 1'b0;
            fb_addr    <= (ROW_W + COL_W)'(0);
            {b2, g2, r2, b1, g1, r1} <= 6'd0;
            addr       <= ROW_W'(0);
            sclk       <= 1'b0;
            lat        <= 1'b0;
            oe_n       <= 1'b1;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sclk       <= 1'b0;
                    lat        <= 1'b0;
                    oe_n       <= 1'b1;
                    frame_done <= 1'b0;
                    if (enable) begin
                        state_r <= ST_PREFETCH;
                        busy    <= 1'b1;
                        row_r   <= ROW_W'(0);
                        plane_r <= PL_W'(0);
                        pf_r    <= 1'b0;
                        fb_rd   <= 1'b1;
                        fb_addr <= {ROW_W'(0), COL_W'(0)};
                    end else begin
                        busy    <= 1'b0;
                        fb_rd   <= 1'b0;
                    end
                end
                ST_PREFETCH: begin
                    if (!pf_r) begin
                        pf_r  <= 1'b1;
                        fb_rd <= 1'b0;
                    end else begin
                        // Column 0 data returned this cycle; the shift begins next.
                        state_r <= ST_SHIFT;
                        col_r   <= COL_W'(0);
                        ph_r    <= PH_W'(0);
                        sclk    <= 1'b0;
                        {b2, g2, r2, b1, g1, r1} <= plane_bits(fb_data, plane_r);
                        // With a 2-cycle column the next read coincides with the column start.
                        if (CLK_DIV == 1) begin
                            fb_rd   <= 1'b1;
                            fb_addr <= {row_r, COL_W'(1)};
                        end else begin
                            fb_rd   <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (ph_r == PH_W'(2 * CLK_DIV - 1)) begin
                        sclk <= 1'b0;
                        if (col_r == COL_W'(COLS - 1)) begin
                            state_r <= ST_BLANK;
                            fb_rd   <= 1'b0;
                        end else begin
                            col_r <= col_r + COL_W'(1);
                            ph_r  <= PH_W'(0);
                            {b2, g2, r2, b1, g1, r1} <= plane_bits(fb_data, plane_r);
                            if ((CLK_DIV == 1) && (col_r != COL_W'(COLS - 2))) begin
                                fb_rd   <= 1'b1;
                                fb_addr <= {row_r, col_r + COL_W'(2)};
                            end else begin
                                fb_rd   <= 1'b0;
                            end
                        end
                    end else begin
                        ph_r <= ph_next_s;
                        sclk <= (ph_next_s >= PH_W'(CLK_DIV));
                        // Read for the next column two cycles before that column starts.
                        if ((ph_next_s == PH_W'(2 * CLK_DIV - 2)) && (col_r != COL_W'(COLS - 1))) begin
                            fb_rd   <= 1'b1;
                            fb_addr <= {row_r, col_r + COL_W'(1)};
                        end else begin
                            fb_rd   <= 1'b0;
                        end
                    end
                end
                ST_BLANK: begin
                    state_r <= ST_LATCH;
                    sclk    <= 1'b0;
                    fb_rd   <= 1'b0;
                    oe_n    <= 1'b1;
                    lat     <= 1'b1;
                    addr    <= row_r;
                    lc_r    <= LC_W'(0);
                end
                ST_LATCH: begin
                    if (lc_r == LC_W'(LAT_W - 1)) begin
                        state_r    <= ST_DISPLAY;
                        lat        <= 1'b0;
                        d_r        <= D_W'(0);
                        bright_r   <= brightness;
                        oe_n       <= (brightness == 8'd0);
                        frame_done <= last_seg_s && (win_last_s == D_W'(0));
                    end else begin
                        lc_r <= lc_r + LC_W'(1);
                    end
                end
                ST_DISPLAY: begin
                    if (d_r == win_last_s) begin
                        oe_n       <= 1'b1;
                        frame_done <= 1'b0;
                        plane_r    <= next_plane_s;
                        row_r      <= next_row_s;
                        if (last_seg_s && !enable) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                            fb_rd   <= 1'b0;
                        end else begin
                            state_r <= ST_PREFETCH;
                            pf_r    <= 1'b0;
                            fb_rd   <= 1'b1;
                            fb_addr <= {next_row_s, COL_W'(0)};
                        end
                    end else begin
                        d_r        <= d_next_s;
                        oe_n       <= !oe_on(d_next_s, plane_r, bright_r);
                        frame_done <= last_seg_s && (d_next_s == win_last_s);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy       <= 1'b0;
                    fb_rd      <= 1'b0;
                    sclk       <= 1'b0;
                    lat        <= 1'b0;
                    oe_n       <= 1'b1;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// -----------------------------------------------------------------------------
// tb_hub75_bcm_scanner
//   Directed bench for hub75_bcm_scanner in a small configuration
//   (COLS=4, ROW_PAIRS=2, BPP=2, CLK_DIV=1, BASE_T=4, LAT_W=1).
//   Per frame segment (row, plane) the schedule relative to its start is:
//     0..1 PREFETCH, 2..9 SHIFT (column c at 2+2c), 10 BLANK, 11 LATCH,
//     12.. DISPLAY for 4<<plane cycles. Segment starts: 0, 16, 36, 52; frame = 72.
//   The framebuffer model returns r1=col, g1=~col, b1={row,row},
//   r2=col^{row,row}, g2=0, b2=3.
// -----------------------------------------------------------------------------
module tb_hub75_bcm_scanner;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [7:0]  brightness;
    logic        fb_rd;
    logic [2:0]  fb_addr;
    logic [11:0] fb_data;
    logic        r1, g1, b1, r2, g2, b2;
    logic [0:0]  addr;
    logic        sclk, lat, oe_n, frame_done, busy;

    int checks;
    int failures;

    logic       cap_sclk[160], cap_lat[160], cap_oe_n[160], cap_fb_rd[160];
    logic       cap_fd[160], cap_busy[160], cap_addr[160];
    logic       cap_r1[160], cap_g1[160], cap_b1[160], cap_r2[160], cap_g2[160], cap_b2[160];
    logic [2:0] cap_fb_addr[160];

    hub75_bcm_scanner #(
        .COLS(4), .ROW_PAIRS(2), .ROW_W(1), .COL_W(2),
        .BPP(2), .CLK_DIV(1), .BASE_T(4), .LAT_W(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .brightness(brightness),
        .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data(fb_data),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
        .addr(addr), .sclk(sclk), .lat(lat), .oe_n(oe_n),
        .frame_done(frame_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer: data valid one cycle after the read strobe.
    always @(posedge clk) begin
        if (fb_rd) begin
            fb_data <= {2'b11, 2'b00, fb_addr[1:0] ^ {fb_addr[2], fb_addr[2]},
                        {fb_addr[2], fb_addr[2]}, ~fb_addr[1:0], fb_addr[1:0]};
        end
    end

    function automatic int seg_of(input int r);
        if (r < 16) return 0;
        else if (r < 36) return 1;
        else if (r < 52) return 2;
        else return 3;
    endfunction

    function automatic int seg_base(input int s);
        case (s)
            0: return 0;
            1: return 16;
            2: return 36;
            default: return 52;
        endcase
    endfunction

    task automatic start_run(input logic [7:0] br);
        rst = 1'b0;
        enable = 1'b0;
        brightness = br;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic capture(input int n, input int drop_at);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap_sclk[k] = sclk;   cap_lat[k] = lat;     cap_oe_n[k] = oe_n;
            cap_fb_rd[k] = fb_rd; cap_fb_addr[k] = fb_addr;
            cap_fd[k] = frame_done; cap_busy[k] = busy; cap_addr[k] = addr[0];
            cap_r1[k] = r1; cap_g1[k] = g1; cap_b1[k] = b1;
            cap_r2[k] = r2; cap_g2[k] = g2; cap_b2[k] = b2;
            if (k == drop_at) enable = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; enable = 1'b0; brightness = 8'd2;
        repeat (2) @(negedge clk);
        checks++;
        if ({oe_n, busy, sclk, lat, fb_rd, frame_done, addr[0], r1} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_values got=%b exp=10000000", {oe_n, busy, sclk, lat, fb_rd, frame_done, addr[0], r1});
        end
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, oe_n, fb_rd} !== 3'b010) begin
                failures++;
                $display("FAIL idle_hold k=%0d got=%b exp=010", k, {busy, oe_n, fb_rd});
            end
        end
        enable = 1'b1;
        repeat (6) @(negedge clk);   // cycle 5: column 1, sclk high, r1=1
        checks++;
        if ({busy, sclk, r1} !== 3'b111) begin
            failures++;
            $display("FAIL mid_shift got=%b exp=111", {busy, sclk, r1});
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({oe_n, busy, sclk, lat, fb_rd, r1} !== 6'b100000) begin
            failures++;
            $display("FAIL async_reset got=%b exp=100000", {oe_n, busy, sclk, lat, fb_rd, r1});
        end
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, oe_n, fb_rd} !== 3'b010) begin
                failures++;
                $display("FAIL post_reset_idle k=%0d got=%b exp=010", k, {busy, oe_n, fb_rd});
            end
        end
    endtask

    task automatic test_timing;
        int r, s, o, row, pl;
        logic e_sclk, e_lat, e_oe_n, e_rd, e_fd;
        logic [2:0] e_fa;
        start_run(8'd2);
        capture(150, -1);
        for (int k = 0; k < 150; k++) begin
            r = k % 72; s = seg_of(r); o = r - seg_base(s); row = s / 2; pl = s % 2;
            e_sclk = (o >= 2) && (o < 10) && (((o - 2) % 2) == 1);
            e_lat  = (o == 11);
            e_oe_n = !((o >= 12) && ((o - 12) < (2 << pl)));
            e_rd   = (o == 0) || (o == 2) || (o == 4) || (o == 6);
            e_fd   = (r == 71);
            e_fa   = 3'(row * 4 + o / 2);
            checks++;
            if ({cap_sclk[k], cap_lat[k], cap_oe_n[k], cap_fb_rd[k], cap_fd[k]} !==
                {e_sclk, e_lat, e_oe_n, e_rd, e_fd}) begin
                failures++;
                $display("FAIL timing k=%0d got(sclk,lat,oe_n,rd,fd)=%b exp=%b", k,
                         {cap_sclk[k], cap_lat[k], cap_oe_n[k], cap_fb_rd[k], cap_fd[k]},
                         {e_sclk, e_lat, e_oe_n, e_rd, e_fd});
            end
            if (e_rd) begin
                checks++;
                if (cap_fb_addr[k] !== e_fa) begin
                    failures++;
                    $display("FAIL fb_addr k=%0d got=%0d exp=%0d", k, cap_fb_addr[k], e_fa);
                end
            end
        end
    endtask

    task automatic test_colour;
        int s, o, row, pl, col;
        logic [1:0] cv, rv;
        logic [5:0] e_c;
        start_run(8'd2);
        capture(72, -1);
        for (int k = 0; k < 72; k++) begin
            s = seg_of(k); o = k - seg_base(s); row = s / 2; pl = s % 2;
            if ((o >= 2) && (o < 10)) begin
                col = (o - 2) / 2;
                cv = 2'(col); rv = {1'(row), 1'(row)};
                e_c = {1'b1, 1'b0, (cv[pl] ^ rv[pl]), rv[pl], ~cv[pl], cv[pl]};
                checks++;
                if ({cap_b2[k], cap_g2[k], cap_r2[k], cap_b1[k], cap_g1[k], cap_r1[k]} !== e_c) begin
                    failures++;
                    $display("FAIL colour k=%0d got(b2g2r2b1g1r1)=%b exp=%b", k,
                             {cap_b2[k], cap_g2[k], cap_r2[k], cap_b1[k], cap_g1[k], cap_r1[k]}, e_c);
                end
            end
        end
    endtask

    task automatic test_brightness;
        int s, o, pl;
        logic e_oe_n;
        start_run(8'd0);
        capture(150, -1);
        for (int k = 0; k < 150; k++) begin
            checks++;
            if ({cap_oe_n[k], cap_fd[k]} !== {1'b1, ((k % 72) == 71)}) begin
                failures++;
                $display("FAIL dark k=%0d got(oe_n,fd)=%b exp=%b", k, {cap_oe_n[k], cap_fd[k]},
                         {1'b1, ((k % 72) == 71)});
            end
        end
        start_run(8'd200);
        capture(72, -1);
        for (int k = 0; k < 72; k++) begin
            s = seg_of(k); o = k - seg_base(s); pl = s % 2;
            e_oe_n = !((o >= 12) && ((o - 12) < (4 << pl)));
            checks++;
            if (cap_oe_n[k] !== e_oe_n) begin
                failures++;
                $display("FAIL bright_full k=%0d got=%b exp=%b", k, cap_oe_n[k], e_oe_n);
            end
        end
    endtask

    task automatic test_enable_drop;
        start_run(8'd2);
        capture(110, 10);
        for (int k = 0; k < 110; k++) begin
            checks++;
            if ({cap_fd[k], cap_busy[k]} !== {(k == 71), (k <= 71)}) begin
                failures++;
                $display("FAIL enable_drop k=%0d got(fd,busy)=%b exp=%b", k,
                         {cap_fd[k], cap_busy[k]}, {(k == 71), (k <= 71)});
            end
            if (k >= 72) begin
                checks++;
                if (cap_fb_rd[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_fb_rd k=%0d got=%b exp=0", k, cap_fb_rd[k]);
                end
            end
        end
    endtask

    task automatic test_address;
        int r, s, o, changes, bad;
        start_run(8'd2);
        capture(144, -1);
        changes = 0; bad = 0;
        for (int k = 0; k < 144; k++) begin
            r = k % 72; s = seg_of(r); o = r - seg_base(s);
            if (o >= 12) begin
                checks++;
                if (cap_addr[k] !== 1'(s / 2)) begin
                    failures++;
                    $display("FAIL addr_display k=%0d got=%b exp=%0d", k, cap_addr[k], s / 2);
                end
            end
            if ((k > 0) && (cap_addr[k] !== cap_addr[k-1])) begin
                changes++;
                if (!(cap_lat[k] && cap_oe_n[k])) bad++;
            end
        end
        checks++;
        if (changes !== 3) begin
            failures++;
            $display("FAIL addr_changes got=%0d exp=3", changes);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL addr_change_window got=%0d exp=0", bad);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        fb_data = 12'h000;
        rst = 1'b0;
        enable = 1'b0;
        brightness = 8'd0;
        test_reset;
        test_timing;
        test_colour;
        test_brightness;
        test_enable_drop;
        test_address;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
